// File: rtl/ecc_ctrl_pkg.sv
// Shared constants and types for the ECC operation sequencer.
package ecc_ctrl_pkg;

  // Register map, decoded on PADDR[4:0]
  localparam logic [4:0] ADDR_CTRL    = 5'h00;
  localparam logic [4:0] ADDR_DATA_IN = 5'h04;
  localparam logic [4:0] ADDR_WIDTH   = 5'h08;
  localparam logic [4:0] ADDR_NOISE   = 5'h0C;
  localparam logic [4:0] ADDR_STATUS  = 5'h10;

  typedef enum logic [1:0] {
    OP_ENC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_FULL = 2'd2
  } op_e;

  // CTRL value that is stored but never launches the core
  localparam logic [1:0] OP_NOP = 2'd3;

  typedef enum logic [1:0] {
    WIDTH_8  = 2'd0,
    WIDTH_16 = 2'd1,
    WIDTH_32 = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Error count reported when the core never answers
  localparam logic [1:0] NERR_TIMEOUT = 2'b10;

  // The core can report 3 errors, but the reported count tops out at 2
  function automatic logic [1:0] sat_nerr(input logic [1:0] nerr);
    return (nerr == 2'b11) ? 2'b10 : nerr;
  endfunction

endpackage

// File: rtl/ecc_apb_regs.sv
// APB register bank: address decode, write-block while busy, read mux, launch detect.
module ecc_apb_regs
  import ecc_ctrl_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       busy,
  input  logic                       timeout_flag,
  output logic                       launch,
  output logic [1:0]                 launch_op,
  output logic [DATA_WIDTH-1:0]      reg_data,
  output logic [1:0]                 reg_width,
  output logic [DATA_WIDTH-1:0]      reg_noise
);

  logic [4:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] reg_ctrl;
  logic       unused_addr_bits;

  assign addr             = PADDR[4:0];
  assign unused_addr_bits = ^PADDR[AMBA_ADDR_WIDTH-1:5];
  // Any write while an operation is in flight is dropped, CTRL included
  assign wr_en     = PSEL & PENABLE & PWRITE & ~busy;
  assign rd_en     = PSEL & PENABLE & ~PWRITE;
  assign launch_op = PWDATA[1:0];
  assign launch    = wr_en && (addr == ADDR_CTRL) && (PWDATA[1:0] != OP_NOP);

  // Register writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_ctrl  <= '0;
      reg_data  <= '0;
      reg_width <= '0;
      reg_noise <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_CTRL:    reg_ctrl  <= PWDATA[1:0];
        ADDR_DATA_IN: reg_data  <= PWDATA[DATA_WIDTH-1:0];
        ADDR_WIDTH:   reg_width <= PWDATA[1:0];
        ADDR_NOISE:   reg_noise <= PWDATA[DATA_WIDTH-1:0];
        default:      ;
      endcase
    end
  end

  // Read mux, zero outside a read access phase
  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:    PRDATA = AMBA_WORD'(reg_ctrl);
        ADDR_DATA_IN: PRDATA = AMBA_WORD'(reg_data);
        ADDR_WIDTH:   PRDATA = AMBA_WORD'(reg_width);
        ADDR_NOISE:   PRDATA = AMBA_WORD'(reg_noise);
        ADDR_STATUS:  PRDATA = AMBA_WORD'({timeout_flag, busy});
        default:      PRDATA = '0;
      endcase
    end
  end

endmodule

// File: rtl/ecc_op_sequencer.sv
// APB-programmed sequencer that launches one ECC core operation per CTRL write.
//
// state | meaning
// IDLE  | waiting for a CTRL write with op < 3
// ISSUE | core_start pulse, operands latched onto core_* outputs
// WAIT  | waiting for core_valid, timeout down-counter running
// DONE  | publish captured result and pulse operation_done
module ecc_op_sequencer
  import ecc_ctrl_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       core_start,
  output logic [1:0]                 core_op,
  output logic [DATA_WIDTH-1:0]      core_data,
  output logic [1:0]                 core_width,
  output logic [DATA_WIDTH-1:0]      core_noise,
  input  logic                       core_valid,
  input  logic [DATA_WIDTH-1:0]      core_result,
  input  logic [1:0]                 core_nerr,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                 state;
  logic                   busy;
  logic                   launch;
  logic [1:0]             launch_op;
  logic [DATA_WIDTH-1:0]  reg_data;
  logic [1:0]             reg_width;
  logic [DATA_WIDTH-1:0]  reg_noise;
  logic                   timeout_flag;
  logic                   tmo_hit;
  logic [CNT_W-1:0]       tmo_cnt;
  logic [DATA_WIDTH-1:0]  res_hold;
  logic [1:0]             nerr_hold;

  assign busy = (state != IDLE);

  ecc_apb_regs #(
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH),
    .AMBA_WORD       (AMBA_WORD),
    .DATA_WIDTH      (DATA_WIDTH)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PENABLE      (PENABLE),
    .PSEL         (PSEL),
    .PWRITE       (PWRITE),
    .PRDATA       (PRDATA),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .launch       (launch),
    .launch_op    (launch_op),
    .reg_data     (reg_data),
    .reg_width    (reg_width),
    .reg_noise    (reg_noise)
  );

  // Sequencer FSM with timeout down-counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      core_start     <= 1'b0;
      core_op        <= '0;
      core_data      <= '0;
      core_width     <= '0;
      core_noise     <= '0;
      data_out       <= '0;
      num_of_errors  <= '0;
      operation_done <= 1'b0;
      timeout_flag   <= 1'b0;
      tmo_hit        <= 1'b0;
      tmo_cnt        <= '0;
      res_hold       <= '0;
      nerr_hold      <= '0;
    end else begin
      core_start     <= 1'b0;
      operation_done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state        <= ISSUE;
            core_start   <= 1'b1;
            core_op      <= launch_op;
            core_data    <= reg_data;
            core_width   <= reg_width;
            core_noise   <= reg_noise;
            timeout_flag <= 1'b0;
            tmo_cnt      <= CNT_W'(TIMEOUT_CYCLES);
          end
        end
        ISSUE: begin
          // core latency is at least one cycle, so valid is not looked at here
          state <= WAIT;
        end
        WAIT: begin
          if (core_valid) begin
            res_hold  <= core_result;
            nerr_hold <= sat_nerr(core_nerr);
            tmo_hit   <= 1'b0;
            state     <= DONE;
          end else if (tmo_cnt == CNT_W'(1)) begin
            res_hold  <= '0;
            nerr_hold <= NERR_TIMEOUT;
            tmo_hit   <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          operation_done <= 1'b1;
          data_out       <= res_hold;
          num_of_errors  <= nerr_hold;
          timeout_flag   <= tmo_hit;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
